// File: rtl/fc_stage.sv
// Firing-control stage: passes monadic packets, pairs dyadic operands in a 128-entry hashed
// waiting memory and returns hash collisions as retries. `define FC_STAT_EN adds fire/retry counters.
module fc_stage (
  input  logic        CP,
  input  logic        MR,
  input  logic        Send_in,
  output logic        Ack_out,
  input  logic [61:0] PACKET_IN,
  input  logic        DEL_in,
  output logic        Send_out,
  input  logic        Ack_in,
  output logic [91:0] PACKET_OUT,
  output logic        RTY,
`ifdef FC_STAT_EN
  output logic [15:0] MATCH_CNT,
  output logic [15:0] COLL_CNT,
`endif
  output logic        ERR
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLook = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [61:0]  pkt_q, pkt_d;
  logic [91:0]  out_q, out_d;
  logic         rty_q, rty_d;
  logic         err_q, err_d;
  logic [127:0] valid_q, valid_d;

  // Entry layout: {tag[17:0] = {CG, NDEST}, side, data[31:0]}
  logic [50:0]  mem_q [128];
  logic [50:0]  rd_entry_q;
  logic         rd_valid_q;
  logic         mem_we;

  logic         accept;
  logic [6:0]   in_idx;
  logic [6:0]   lk_idx;
  logic         tag_hit;
  logic         side_diff;

  assign accept    = Send_in && (state_q == StIdle);
  assign in_idx    = PACKET_IN[50:44] ^ PACKET_IN[57:51];
  assign lk_idx    = pkt_q[50:44] ^ pkt_q[57:51];
  assign tag_hit   = (rd_entry_q[50:33] == pkt_q[61:44]);
  assign side_diff = (rd_entry_q[32] != pkt_q[33]);

  assign Ack_out    = (state_q == StIdle);
  assign Send_out   = (state_q == StEmit);
  assign PACKET_OUT = out_q;
  assign RTY        = rty_q;
  assign ERR        = err_q;

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    out_d   = out_q;
    rty_d   = rty_q;
    err_d   = err_q;
    valid_d = valid_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (Send_in) begin
          pkt_d = PACKET_IN;
          if (DEL_in) begin
            if (!PACKET_IN[32]) begin
              out_d   = {PACKET_IN[61:34], PACKET_IN[31:0], 32'h0};
              rty_d   = 1'b0;
              state_d = StEmit;
            end else begin
              state_d = StLook;
            end
          end
        end
      end
      StLook: begin
        if (!rd_valid_q) begin
          mem_we          = 1'b1;
          valid_d[lk_idx] = 1'b1;
          state_d         = StIdle;
        end else if (tag_hit && side_diff) begin
          valid_d[lk_idx] = 1'b0;
          // Left operand always lands in LDATA regardless of arrival order
          out_d   = {pkt_q[61:34],
                     pkt_q[33] ? rd_entry_q[31:0] : pkt_q[31:0],
                     pkt_q[33] ? pkt_q[31:0] : rd_entry_q[31:0]};
          rty_d   = 1'b0;
          state_d = StEmit;
        end else if (tag_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          out_d   = {30'h0, pkt_q};
          rty_d   = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (Ack_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q    <= StIdle;
      pkt_q      <= '0;
      out_q      <= '0;
      rty_q      <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      out_q   <= out_d;
      rty_q   <= rty_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      if (accept) rd_valid_q <= valid_q[in_idx];
    end
  end

  // Entry payload is not reset; only the valid bits gate its use.
  always_ff @(posedge CP) begin
    if (mem_we) mem_q[lk_idx] <= {pkt_q[61:44], pkt_q[33], pkt_q[31:0]};
    if (accept) rd_entry_q <= mem_q[in_idx];
  end

`ifdef FC_STAT_EN
  logic fire_evt;
  logic coll_evt;
  logic [15:0] match_cnt_q;
  logic [15:0] coll_cnt_q;

  assign fire_evt  = (state_q == StLook) && rd_valid_q && tag_hit && side_diff;
  assign coll_evt  = (state_q == StLook) && rd_valid_q && !tag_hit;
  assign MATCH_CNT = match_cnt_q;
  assign COLL_CNT  = coll_cnt_q;

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      match_cnt_q <= '0;
      coll_cnt_q  <= '0;
    end else begin
      if (fire_evt) match_cnt_q <= match_cnt_q + 16'd1;
      if (coll_evt) coll_cnt_q  <= coll_cnt_q + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_fc_stage.sv
// Bench for fc_stage: directed scenarios plus a random stream checked against an array-based
// model of the waiting memory. Counter checks apply when FC_STAT_EN is defined.
module tb_fc_stage;

  logic        CP = 1'b0;
  logic        MR = 1'b1;
  logic        Send_in = 1'b0;
  logic        Ack_out;
  logic [61:0] PACKET_IN = '0;
  logic        DEL_in = 1'b1;
  logic        Send_out;
  logic        Ack_in = 1'b1;
  logic [91:0] PACKET_OUT;
  logic        RTY;
  logic        ERR;
`ifdef FC_STAT_EN
  logic [15:0] match_cnt;
  logic [15:0] coll_cnt;
`endif

  int errors = 0;
  int checks = 0;

  bit          mv    [128];
  logic [17:0] mtag  [128];
  bit          mside [128];
  logic [31:0] mdata [128];
  bit          merr;
  int          mfire;
  int          mcoll;

  fc_stage dut (
    .CP(CP),
    .MR(MR),
    .Send_in(Send_in),
    .Ack_out(Ack_out),
    .PACKET_IN(PACKET_IN),
    .DEL_in(DEL_in),
    .Send_out(Send_out),
    .Ack_in(Ack_in),
    .PACKET_OUT(PACKET_OUT),
    .RTY(RTY),
`ifdef FC_STAT_EN
    .MATCH_CNT(match_cnt),
    .COLL_CNT(coll_cnt),
`endif
    .ERR(ERR)
  );

  always #5 CP = ~CP;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [91:0] obs, input logic [91:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [61:0] mk(input logic [10:0] cg, input logic [6:0] nd,
                                     input logic [3:0] ctrl, input logic [5:0] opc,
                                     input logic side, input logic match,
                                     input logic [31:0] data);
    return {cg, nd, ctrl, opc, side, match, data};
  endfunction

  task automatic model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    merr  = 1'b0;
    mfire = 0;
    mcoll = 0;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_ack"}, 92'(Ack_out), 92'(1));
    chk({tag, "_send"}, 92'(Send_out), 92'(0));
    chk({tag, "_err"}, 92'(ERR), 92'(merr));
`ifdef FC_STAT_EN
    chk({tag, "_mcnt"}, 92'(match_cnt), 92'(16'(mfire)));
    chk({tag, "_ccnt"}, 92'(coll_cnt), 92'(16'(mcoll)));
`endif
  endtask

  // Called at posedge+1 with the DUT idle; leaves it idle at posedge+1.
  task automatic xact(input string tag, input logic [61:0] p, input bit del, input int stall);
    bit          emit;
    bit          two;
    bit          exp_rty;
    logic [91:0] exp_out;
    logic [6:0]  idx;
    logic [17:0] tg;
    idx     = p[50:44] ^ p[57:51];
    tg      = p[61:44];
    emit    = 1'b0;
    two     = 1'b0;
    exp_rty = 1'b0;
    exp_out = '0;
    if (del) begin
      if (!p[32]) begin
        emit    = 1'b1;
        exp_out = {p[61:34], p[31:0], 32'h0};
      end else begin
        two = 1'b1;
        if (!mv[idx]) begin
          mv[idx]    = 1'b1;
          mtag[idx]  = tg;
          mside[idx] = p[33];
          mdata[idx] = p[31:0];
        end else if (mtag[idx] == tg && mside[idx] != p[33]) begin
          mv[idx] = 1'b0;
          emit    = 1'b1;
          if (p[33]) exp_out = {p[61:34], mdata[idx], p[31:0]};
          else       exp_out = {p[61:34], p[31:0], mdata[idx]};
          mfire++;
        end else if (mtag[idx] == tg) begin
          merr = 1'b1;
        end else begin
          emit    = 1'b1;
          exp_rty = 1'b1;
          exp_out = {30'h0, p};
          mcoll++;
        end
      end
    end

    Ack_in    = (stall == 0);
    Send_in   = 1'b1;
    PACKET_IN = p;
    DEL_in    = del;
    @(posedge CP);
    #1;
    Send_in = 1'b0;
    if (two) begin
      chk({tag, "_look_ack"}, 92'(Ack_out), 92'(0));
      chk({tag, "_look_send"}, 92'(Send_out), 92'(0));
      @(posedge CP);
      #1;
    end
    if (emit) begin
      chk({tag, "_send"}, 92'(Send_out), 92'(1));
      chk({tag, "_emit_ack"}, 92'(Ack_out), 92'(0));
      chk({tag, "_pkt"}, PACKET_OUT, exp_out);
      chk({tag, "_rty"}, 92'(RTY), 92'(exp_rty));
      for (int i = 0; i < stall; i++) begin
        @(posedge CP);
        #1;
        chk({tag, "_hold_send"}, 92'(Send_out), 92'(1));
        chk({tag, "_hold_pkt"}, PACKET_OUT, exp_out);
      end
      Ack_in = 1'b1;
      @(posedge CP);
      #1;
    end
    idle_checks(tag);
  endtask

  initial begin
    logic [61:0] p;
    logic [61:0] left_p;
    logic [91:0] mono_exp;
    logic [10:0] cg;
    model_reset();
    @(posedge CP);
    #1;
    MR = 1'b0;
    chk("rst_ack", 92'(Ack_out), 92'(1));
    chk("rst_send", 92'(Send_out), 92'(0));
    chk("rst_pkt", PACKET_OUT, 92'(0));
    chk("rst_rty", 92'(RTY), 92'(0));
    chk("rst_err", 92'(ERR), 92'(0));

    xact("mono", mk(11'h001, 7'h05, 4'h0, 6'h02, 1'b0, 1'b0, 32'h12345678), 1'b1, 0);
    chk("mono_l", 92'(PACKET_OUT[63:32]), 92'(32'h12345678));

    xact("pair_r", mk(11'h003, 7'h10, 4'h1, 6'h07, 1'b1, 1'b1, 32'hA), 1'b1, 0);
    xact("pair_l", mk(11'h003, 7'h10, 4'h2, 6'h09, 1'b0, 1'b1, 32'hB), 1'b1, 0);
    // Entry 0x13 must be free again: the same right operand is stored, not fired
    xact("pair_again", mk(11'h003, 7'h10, 4'h1, 6'h07, 1'b1, 1'b1, 32'hC), 1'b1, 0);

    xact("coll_st", mk(11'h000, 7'h01, 4'h3, 6'h01, 1'b0, 1'b1, 32'h1111), 1'b1, 0);
    xact("coll", mk(11'h001, 7'h00, 4'h4, 6'h03, 1'b1, 1'b1, 32'h2222), 1'b1, 0);
    xact("coll_fire", mk(11'h000, 7'h01, 4'h5, 6'h04, 1'b1, 1'b1, 32'h3333), 1'b1, 0);

    xact("del0", mk(11'h022, 7'h22, 4'h0, 6'h00, 1'b0, 1'b1, 32'hDEAD), 1'b0, 0);
    xact("del0_mono", mk(11'h022, 7'h22, 4'h0, 6'h00, 1'b0, 1'b0, 32'hBEEF), 1'b0, 0);

    xact("dup1", mk(11'h010, 7'h30, 4'h0, 6'h11, 1'b0, 1'b1, 32'h100), 1'b1, 0);
    xact("dup2", mk(11'h010, 7'h30, 4'h0, 6'h11, 1'b0, 1'b1, 32'h200), 1'b1, 0);
    xact("dup_fire", mk(11'h010, 7'h30, 4'h0, 6'h12, 1'b1, 1'b1, 32'h300), 1'b1, 0);
    xact("err_sticky", mk(11'h0F0, 7'h01, 4'h0, 6'h01, 1'b0, 1'b0, 32'h7), 1'b1, 0);

    left_p = mk(11'h005, 7'h20, 4'h6, 6'h05, 1'b0, 1'b1, 32'h55);
    xact("bp_store", left_p, 1'b1, 0);
    p        = mk(11'h044, 7'h44, 4'h9, 6'h3F, 1'b0, 1'b0, 32'hCAFE0001);
    mono_exp = {p[61:34], p[31:0], 32'h0};
    Ack_in    = 1'b0;
    Send_in   = 1'b1;
    PACKET_IN = p;
    DEL_in    = 1'b1;
    @(posedge CP);
    #1;
    Send_in = 1'b0;
    chk("bp_send", 92'(Send_out), 92'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge CP);
      #1;
      chk("bp_hold_send", 92'(Send_out), 92'(1));
      chk("bp_hold_pkt", PACKET_OUT, mono_exp);
    end
    MR = 1'b1;
    #2;
    chk("mr_send", 92'(Send_out), 92'(0));
    chk("mr_ack", 92'(Ack_out), 92'(1));
    chk("mr_err", 92'(ERR), 92'(0));
    chk("mr_pkt", PACKET_OUT, 92'(0));
    MR     = 1'b0;
    Ack_in = 1'b1;
    model_reset();
    xact("post_mr", mk(11'h005, 7'h20, 4'h6, 6'h05, 1'b1, 1'b1, 32'h66), 1'b1, 0);

    for (int n = 0; n < 300; n++) begin
      cg = {($urandom_range(0, 1) != 0) ? 4'hA : 4'h0, 7'($urandom_range(0, 3))};
      p  = mk(cg, 7'($urandom_range(0, 3)), 4'($urandom), 6'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom);
      xact("rand", p, $urandom_range(0, 7) != 0, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
